// File: rtl/instruction_encoder.sv
// instruction_encoder: packs instruction fields into 16-bit words, buffers them in a small
// FIFO and streams them into instruction memory starting at a captured base address.
//
// Optional feature: define ENC_ILLEGAL_CHECK_EN to drop opcode=000 words and raise the
// sticky err_illegal flag (the err_illegal port exists only in that build).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr        open a load session (IDLE only), first write address
//   in_valid/in_ready       field-input handshake, in_last marks the session's final word
//   opcode..imm5            instruction fields to encode
//   mem_we/mem_addr/
//   mem_wdata/mem_ready     instruction-memory write port
//   busy, done, word_count  session status
//   err_illegal             sticky illegal-opcode flag (ENC_ILLEGAL_CHECK_EN only)
module instruction_encoder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   input  logic [2:0]        Rn,
   input  logic [2:0]        Rd,
   input  logic [1:0]        sh,
   input  logic [2:0]        Rm,
   input  logic [7:0]        imm8,
   input  logic [4:0]        imm5,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count
`ifdef ENC_ILLEGAL_CHECK_EN
   ,
   output logic              err_illegal
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned WcW  = ADDR_W + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [15:0]         fifo_q [DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     wc_q;
   logic [15:0]         enc_word;
   logic                fifo_empty, fifo_full;
   logic                accept, push, pop, start_ok;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CntW'(DEPTH));
   assign start_ok   = (state_q == StIdle) && start;

   // No bypass when full: a pop in the same cycle does not open the input.
   assign in_ready = (state_q == StRun) && !fifo_full;
   assign accept   = in_valid && in_ready;
   assign mem_we   = ((state_q == StRun) || (state_q == StDrain)) && !fifo_empty;
   assign pop      = mem_we && mem_ready;

   // Gated so the write port reads zero whenever nothing is buffered (incl. reset).
   assign mem_wdata  = fifo_empty ? 16'h0000 : fifo_q[rd_ptr_q];
   assign mem_addr   = addr_q;
   assign word_count = wc_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);

   always_comb begin
      enc_word = {opcode, op, Rn, Rd, sh, Rm};
      if (opcode == 3'b110 && op == 2'b10) begin
         enc_word = {opcode, op, Rn, imm8};
      end else if (opcode == 3'b011 || opcode == 3'b100) begin
         enc_word = {opcode, op, Rn, Rd, imm5};
      end
   end

`ifdef ENC_ILLEGAL_CHECK_EN
   logic illegal;
   logic err_q;

   assign illegal     = (opcode == 3'b000);
   assign push        = accept && !illegal;
   assign err_illegal = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (start_ok) begin
         err_q <= 1'b0;
      end else if (accept && illegal) begin
         err_q <= 1'b1;
      end
   end
`else
   assign push = accept;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         // An illegal last word still ends the input phase.
         StRun:   if (accept && in_last) state_d = StDrain;
         StDrain: if (fifo_empty) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wc_q     <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CntW'(1);
         end
         if (start_ok) begin
            addr_q <= base_addr;
            wc_q   <= '0;
         end else if (pop) begin
            addr_q <= addr_q + ADDR_W'(1);
            wc_q   <= wc_q + WcW'(1);
         end
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= enc_word;
   end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, in_valid, in_ready, in_last, mem_we, mem_ready;
   logic          busy, done;
   logic [AW-1:0] base_addr, mem_addr;
   logic [2:0]    opcode, Rn, Rd, Rm;
   logic [1:0]    op, sh;
   logic [7:0]    imm8;
   logic [4:0]    imm5;
   logic [15:0]   mem_wdata;
   logic [AW:0]   word_count;
`ifdef ENC_ILLEGAL_CHECK_EN
   logic          err_illegal;
`endif

   instruction_encoder #(.ADDR_W(AW), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .opcode     (opcode),
      .op         (op),
      .Rn         (Rn),
      .Rd         (Rd),
      .sh         (sh),
      .Rm         (Rm),
      .imm8       (imm8),
      .imm5       (imm5),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .busy       (busy),
      .done       (done),
      .word_count (word_count)
`ifdef ENC_ILLEGAL_CHECK_EN
      ,
      .err_illegal(err_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] opc; logic [1:0] op; logic [2:0] rn; logic [2:0] rd;
      logic [1:0] sh;  logic [2:0] rm; logic [7:0] imm8; logic [4:0] imm5;
   } word_t;

   word_t         words[$];
   word_t         cur;
   logic [15:0]   exp_q[$];
   logic [15:0]   wr_data_log[$];
   logic [AW-1:0] wr_addr_log[$];
   logic [AW-1:0] model_addr;
   int            passed = 0, total = 0, fails = 0;
   int            n_written, done_cycles, wc_at_done;
   bit            ill_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoding: field values placed by weight, straight from the format rules.
   function automatic logic [15:0] enc(input word_t w);
      int v;
      v = w.opc * 8192 + w.op * 2048 + w.rn * 256;
      if (w.opc == 3'd6 && w.op == 2'd2)       v = v + w.imm8;
      else if (w.opc == 3'd3 || w.opc == 3'd4) v = v + w.rd * 32 + w.imm5;
      else                                      v = v + w.rd * 32 + w.sh * 8 + w.rm;
      return v[15:0];
   endfunction

   function automatic bit legal(input word_t w);
`ifdef ENC_ILLEGAL_CHECK_EN
      return w.opc != 3'd0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic word_t mk(input int opc, op, rn, rd, s, rm, i8, i5);
      word_t w;
      w.opc = opc[2:0]; w.op = op[1:0]; w.rn = rn[2:0]; w.rd = rd[2:0];
      w.sh = s[1:0]; w.rm = rm[2:0]; w.imm8 = i8[7:0]; w.imm5 = i5[4:0];
      return w;
   endfunction

   function automatic word_t rnd_word(input bit force_legal);
      word_t w;
      w = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      if (force_legal && w.opc == 3'd0) w.opc = 3'd5;
      return w;
   endfunction

   function automatic int legal_count();
      int n = 0;
      foreach (words[i]) if (legal(words[i])) n++;
      return n;
   endfunction

   task automatic drive(input word_t w);
      cur = w;
      opcode = w.opc; op = w.op; Rn = w.rn; Rd = w.rd;
      sh = w.sh; Rm = w.rm; imm8 = w.imm8; imm5 = w.imm5;
   endtask

   // Observe one cycle (writes first, then the accept), then advance to just after the edge.
   task automatic tick(output bit acc);
      #1;
      if (mem_we && mem_ready) begin
         wr_data_log.push_back(mem_wdata);
         wr_addr_log.push_back(mem_addr);
         if (exp_q.size() == 0) begin
            check("unexpected_write", mem_we, 0);
         end else begin
            check("wr_addr", mem_addr, model_addr);
            check("wr_data", mem_wdata, exp_q.pop_front());
            model_addr = model_addr + 1'b1;
            n_written++;
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         if (legal(cur)) exp_q.push_back(enc(cur));
         else ill_seen = 1'b1;
      end
      if (done) begin
         done_cycles++;
         wc_at_done = int'(word_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input logic [AW-1:0] base);
      bit a;
      start = 1'b1; base_addr = base;
      model_addr = base; n_written = 0; done_cycles = 0; wc_at_done = 0; ill_seen = 1'b0;
      wr_data_log.delete(); wr_addr_log.delete();
      tick(a);
      start = 1'b0; base_addr = AW'($urandom);
      check("busy_after_start", busy, 1);
      check("wc_cleared", word_count, 0);
`ifdef ENC_ILLEGAL_CHECK_EN
      check("err_cleared", err_illegal, 0);
`endif
   endtask

   task automatic send_words(input int from, input int ready_pct, input int valid_pct,
                             input bit poke);
      bit a;
      int idx = from, guard = 0;
      while (idx < words.size() && guard < 500) begin
         drive(words[idx]);
         in_last   = (idx == words.size() - 1);
         in_valid  = ($urandom_range(0, 99) < valid_pct);
         mem_ready = ($urandom_range(0, 99) < ready_pct);
         if (poke) begin
            start = $urandom_range(0, 1); base_addr = AW'($urandom);
         end
         tick(a);
         if (a) idx++;
         guard++;
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      check("all_words_accepted", idx, words.size());
   endtask

   task automatic finish_session(input int ready_pct, input int exp_cnt);
      bit a;
      int guard = 0;
      while (done_cycles == 0 && guard < 200) begin
         mem_ready = ($urandom_range(0, 99) < ready_pct);
         tick(a);
         guard++;
      end
      tick(a);
      check("done_pulse_once", done_cycles, 1);
      check("wc_at_done", wc_at_done, exp_cnt);
      check("writes", n_written, exp_cnt);
      check("queue_drained", exp_q.size(), 0);
      check("idle_after_done", busy, 0);
`ifdef ENC_ILLEGAL_CHECK_EN
      check("err_sticky", err_illegal, ill_seen);
`endif
   endtask

   initial begin
      bit a;
      logic          s_we;
      logic [AW-1:0] s_addr;
      logic [15:0]   s_data;
      int            idx;

      rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
      mem_ready = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_word_count", word_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single ALU word, with one-cycle accept-to-write latency.
      words.delete();
      words.push_back(mk(5, 0, 1, 2, 1, 0, $urandom, $urandom));
      start_session(8'h10);
      drive(words[0]); in_last = 1'b1; in_valid = 1'b1; mem_ready = 1'b1;
      tick(a);
      check("single_accept", a, 1);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      check("latency_we", mem_we, 1);
      check("single_data", mem_wdata, 16'hA148);
      check("single_addr", mem_addr, 8'h10);
      finish_session(100, 1);

      // MOV immediate then LDR immediate-offset.
      words.delete();
      words.push_back(mk(6, 2, 3, $urandom, $urandom, $urandom, 8'h2A, $urandom));
      words.push_back(mk(3, 0, 2, 1, $urandom, $urandom, $urandom, 5));
      start_session(8'h20);
      send_words(0, 100, 100, 1'b0);
      finish_session(100, 2);
      check("mov_data", wr_data_log[0], 16'hD32A);
      check("ldr_data", wr_data_log[1], 16'h6225);
      check("ldr_addr", wr_addr_log[1], 8'h21);

      // Memory stalled: FIFO fills at four words and the write port holds still.
      words.delete();
      for (int i = 0; i < 5; i++) words.push_back(rnd_word(1'b1));
      start_session(8'h40);
      idx = 0;
      mem_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         drive(words[idx]); in_last = (idx == 4); in_valid = 1'b1;
         tick(a);
         if (a) idx++;
      end
      check("accepts_while_stalled", idx, 4);
      #1;
      check("in_ready_full", in_ready, 0);
      s_we = mem_we; s_addr = mem_addr; s_data = mem_wdata;
      check("stall_we", s_we, 1);
      check("stall_addr", s_addr, 8'h40);
      check("stall_data", s_data, enc(words[0]));
      for (int c = 0; c < 3; c++) begin
         tick(a);
         check("hold_we", mem_we, s_we);
         check("hold_addr", mem_addr, s_addr);
         check("hold_data", mem_wdata, s_data);
      end
      send_words(4, 100, 100, 1'b0);
      finish_session(100, 5);

      // Address wrap.
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back(rnd_word(1'b1));
      start_session(8'hFE);
      send_words(0, 100, 100, 1'b0);
      finish_session(100, 3);
      check("wrap_a0", wr_addr_log[0], 8'hFE);
      check("wrap_a1", wr_addr_log[1], 8'hFF);
      check("wrap_a2", wr_addr_log[2], 8'h00);

      // Reset mid-session with three words buffered.
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back(rnd_word(1'b1));
      start_session(8'h30);
      send_words(0, 0, 100, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", mem_we, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_wc", word_count, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick(a);
         check("postrst_we", mem_we, 0);
         check("postrst_busy", busy, 0);
      end
      words.delete();
      words.push_back(mk(5, 0, 1, 2, 1, 0, $urandom, $urandom));
      start_session(8'h00);
      send_words(0, 100, 100, 1'b0);
      finish_session(100, 1);
      check("postrst_data", wr_data_log[0], 16'hA148);
      check("postrst_addr", wr_addr_log[0], 8'h00);

`ifdef ENC_ILLEGAL_CHECK_EN
      // Illegal word dropped; the legal last word still closes the session.
      words.delete();
      words.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      words.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0));
      start_session(8'h50);
      send_words(0, 100, 100, 1'b0);
      finish_session(100, 1);
      check("ill_data", wr_data_log[0], 16'hE000);
      check("ill_flag", err_illegal, 1);
`endif

      // Randomized sessions with backpressure, gaps and stray start pulses.
      for (int s = 0; s < 8; s++) begin
         int n;
         n = $urandom_range(1, 9);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back(rnd_word(1'b0));
         start_session(AW'($urandom));
         send_words(0, $urandom_range(30, 100), $urandom_range(40, 100), 1'b1);
         finish_session($urandom_range(30, 100), legal_count());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
